// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 miss arbiter: FSM state encoding,
// requester (owner) identifiers and the default watchdog limit.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_I = 2'd0;
    localparam owner_t OWN_D = 2'd1;
    localparam owner_t OWN_W = 2'd2;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd1024;

    // Round-robin successor in the order I -> D -> W -> I; the unused code wraps to I.
    function automatic owner_t next_owner(input owner_t id);
        owner_t nxt;
        case (id)
            OWN_I:   nxt = OWN_D;
            OWN_D:   nxt = OWN_W;
            default: nxt = OWN_I;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/l2_rr_pick.sv
// Three-way round-robin picker. Searches req starting at ptr in the order
// I -> D -> W -> I and returns the winner both one-hot and as an owner id.
// Purely combinational; the caller registers whatever it derives from it.
module l2_rr_pick
    import l2_arb_pkg::*;
(
    input  logic [2:0] req,
    input  owner_t     ptr,
    output logic [2:0] grant,
    output owner_t     grant_id,
    output logic       any
);

    owner_t cand0;
    owner_t cand1;
    owner_t cand2;

    // Priority search over the three rotated candidates beginning at ptr.
    always_comb begin
        cand0    = (ptr > OWN_W) ? OWN_I : ptr;
        cand1    = next_owner(cand0);
        cand2    = next_owner(cand1);
        grant    = 3'b000;
        grant_id = cand0;
        any      = |req;
        if (req[cand0]) begin
            grant_id = cand0;
        end else if (req[cand1]) begin
            grant_id = cand1;
        end else if (req[cand2]) begin
            grant_id = cand2;
        end else begin
            grant_id = cand0;
        end
        if (any) begin
            grant[grant_id] = 1'b1;
        end else begin
            grant = 3'b000;
        end
    end

endmodule

// File: rtl/l2_miss_arbiter.sv
// L2 miss arbiter: grants one of I-miss / D-miss / D-write by round-robin,
// issues a single L3 transaction, waits for the response and routes it to
// the owner and (for reads) to the L2 fill port. One transaction in flight.
// Optional watchdog in WAIT_RESP is enabled by defining L2_ARB_TIMEOUT_EN.
module l2_miss_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk_a,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_ack,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ack,
    output logic              l3_req_valid,
    input  logic              l3_req_ready,
    output logic              l3_req_we,
    output logic [ADDR_W-1:0] l3_addr,
    output logic [DATA_W-1:0] l3_wdata,
    input  logic              l3_resp_valid,
    input  logic [DATA_W-1:0] l3_resp_data,
    output logic              i_fill_valid,
    output logic              d_fill_valid,
    output logic              w_done,
    output logic [DATA_W-1:0] fill_data,
    output logic              cache_read_start,
    output logic [ADDR_W-1:0] cache_read,
    output logic [DATA_W-1:0] cache_in,
    output logic              busy,
    output logic              timeout_err
);

    arb_state_t        state_r, state_n;
    owner_t            owner_r, owner_n;
    owner_t            rr_ptr_r, rr_ptr_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [DATA_W-1:0] wdata_r, wdata_n;
    logic              we_r, we_n;
    logic [2:0]        ack_r, ack_n;
    logic              l3_valid_r, l3_valid_n;
    logic [2:0]        done_r, done_n;
    logic [DATA_W-1:0] fill_data_r, fill_data_n;
    logic              crs_r, crs_n;
    logic [ADDR_W-1:0] cache_read_r, cache_read_n;
    logic [DATA_W-1:0] cache_in_r, cache_in_n;
    logic              busy_r, busy_n;
    logic              tmo_r, tmo_n;

    logic [2:0]        grant_s;
    owner_t            grant_id_s;
    logic              any_req_s;

`ifdef L2_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
    logic [15:0]       wd_cnt_r, wd_cnt_n;
`endif

    l2_rr_pick u_pick (
        .req      ({w_req, d_req, i_req}),
        .ptr      (rr_ptr_r),
        .grant    (grant_s),
        .grant_id (grant_id_s),
        .any      (any_req_s)
    );

    // Next-state and next-output computation for the IDLE/ISSUE/WAIT_RESP sequencer.
    always_comb begin
        state_n      = state_r;
        owner_n      = owner_r;
        rr_ptr_n     = rr_ptr_r;
        addr_n       = addr_r;
        wdata_n      = wdata_r;
        we_n         = we_r;
        ack_n        = 3'b000;
        l3_valid_n   = l3_valid_r;
        done_n       = 3'b000;
        fill_data_n  = fill_data_r;
        crs_n        = 1'b0;
        cache_read_n = cache_read_r;
        cache_in_n   = cache_in_r;
        tmo_n        = tmo_r;
`ifdef L2_ARB_TIMEOUT_EN
        wd_cnt_n     = wd_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    owner_n    = grant_id_s;
                    rr_ptr_n   = next_owner(grant_id_s);
                    ack_n      = grant_s;
                    l3_valid_n = 1'b1;
                    state_n    = ISSUE;
                    case (grant_id_s)
                        OWN_I: begin
                            addr_n  = i_addr;
                            wdata_n = {DATA_W{1'b0}};
                            we_n    = 1'b0;
                        end
                        OWN_D: begin
                            addr_n  = d_addr;
                            wdata_n = {DATA_W{1'b0}};
                            we_n    = 1'b0;
                        end
                        default: begin
                            addr_n  = w_addr;
                            wdata_n = w_data;
                            we_n    = 1'b1;
                        end
                    endcase
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (l3_valid_r && l3_req_ready) begin
                    l3_valid_n = 1'b0;
                    state_n    = WAIT_RESP;
`ifdef L2_ARB_TIMEOUT_EN
                    wd_cnt_n   = 16'd0;
`endif
                end else begin
                    state_n = ISSUE;
                end
            end
            WAIT_RESP: begin
                if (l3_resp_valid) begin
                    state_n     = IDLE;
                    fill_data_n = l3_resp_data;
                    case (owner_r)
                        OWN_I: begin
                            done_n       = 3'b001;
                            crs_n        = 1'b1;
                            cache_read_n = addr_r;
                            cache_in_n   = l3_resp_data;
                        end
                        OWN_D: begin
                            done_n       = 3'b010;
                            crs_n        = 1'b1;
                            cache_read_n = addr_r;
                            cache_in_n   = l3_resp_data;
                        end
                        default: begin
                            done_n = 3'b100;
                        end
                    endcase
`ifdef L2_ARB_TIMEOUT_EN
                end else if (wd_cnt_r == TIMEOUT_LAST) begin
                    // Give up on the response: flag it and release the owner with zero data.
                    state_n     = IDLE;
                    tmo_n       = 1'b1;
                    fill_data_n = {DATA_W{1'b0}};
                    case (owner_r)
                        OWN_I:   done_n = 3'b001;
                        OWN_D:   done_n = 3'b010;
                        default: done_n = 3'b100;
                    endcase
                end else begin
                    wd_cnt_n = wd_cnt_r + 16'd1;
                end
`else
                end else begin
                    state_n = WAIT_RESP;
                end
`endif
            end
            default: begin
                state_n    = IDLE;
                l3_valid_n = 1'b0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, payload and output registers with synchronous reset.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= OWN_I;
            rr_ptr_r     <= OWN_I;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            we_r         <= 1'b0;
            ack_r        <= 3'b000;
            l3_valid_r   <= 1'b0;
            done_r       <= 3'b000;
            fill_data_r  <= {DATA_W{1'b0}};
            crs_r        <= 1'b0;
            cache_read_r <= {ADDR_W{1'b0}};
            cache_in_r   <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
            tmo_r        <= 1'b0;
        end else begin
            state_r      <= state_n;
            owner_r      <= owner_n;
            rr_ptr_r     <= rr_ptr_n;
            addr_r       <= addr_n;
            wdata_r      <= wdata_n;
            we_r         <= we_n;
            ack_r        <= ack_n;
            l3_valid_r   <= l3_valid_n;
            done_r       <= done_n;
            fill_data_r  <= fill_data_n;
            crs_r        <= crs_n;
            cache_read_r <= cache_read_n;
            cache_in_r   <= cache_in_n;
            busy_r       <= busy_n;
            tmo_r        <= tmo_n;
        end
    end

`ifdef L2_ARB_TIMEOUT_EN
    // Watchdog counter for the WAIT_RESP state.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            wd_cnt_r <= 16'd0;
        end else begin
            wd_cnt_r <= wd_cnt_n;
        end
    end
`endif

    assign i_ack            = ack_r[0];
    assign d_ack            = ack_r[1];
    assign w_ack            = ack_r[2];
    assign l3_req_valid     = l3_valid_r;
    assign l3_req_we        = we_r;
    assign l3_addr          = addr_r;
    assign l3_wdata         = wdata_r;
    assign i_fill_valid     = done_r[0];
    assign d_fill_valid     = done_r[1];
    assign w_done           = done_r[2];
    assign fill_data        = fill_data_r;
    assign cache_read_start = crs_r;
    assign cache_read       = cache_read_r;
    assign cache_in         = cache_in_r;
    assign busy             = busy_r;
    assign timeout_err      = tmo_r;

endmodule

// File: tb/tb_l2_miss_arbiter.sv
// Directed self-checking bench for l2_miss_arbiter. Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// The watchdog scenario is exercised when L2_ARB_TIMEOUT_EN is defined.
module tb_l2_miss_arbiter;

    logic        clk_a = 1'b0;
    logic        reset;
    logic        i_req, d_req, w_req;
    logic [63:0] i_addr, d_addr, w_addr, w_data;
    logic        i_ack, d_ack, w_ack;
    logic        l3_req_valid, l3_req_ready, l3_req_we;
    logic [63:0] l3_addr, l3_wdata;
    logic        l3_resp_valid;
    logic [63:0] l3_resp_data;
    logic        i_fill_valid, d_fill_valid, w_done;
    logic [63:0] fill_data;
    logic        cache_read_start;
    logic [63:0] cache_read, cache_in;
    logic        busy, timeout_err;

    int errors = 0;
    int checks = 0;

    l2_miss_arbiter #(
        .ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_a(clk_a), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ack(w_ack),
        .l3_req_valid(l3_req_valid), .l3_req_ready(l3_req_ready),
        .l3_req_we(l3_req_we), .l3_addr(l3_addr), .l3_wdata(l3_wdata),
        .l3_resp_valid(l3_resp_valid), .l3_resp_data(l3_resp_data),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid), .w_done(w_done),
        .fill_data(fill_data), .cache_read_start(cache_read_start),
        .cache_read(cache_read), .cache_in(cache_in),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk_a = ~clk_a;

    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] flags;
        i_req = 1'b0; d_req = 1'b0; w_req = 1'b0;
        i_addr = 64'h0; d_addr = 64'h0; w_addr = 64'h0; w_data = 64'h0;
        l3_req_ready = 1'b0; l3_resp_valid = 1'b0; l3_resp_data = 64'h0;
        do_reset();
        flags = {i_ack, d_ack, w_ack, l3_req_valid, l3_req_we, i_fill_valid, d_fill_valid, w_done, cache_read_start};
        checks++; if (flags !== 9'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000000", flags); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        checks++; if (l3_addr !== 64'h0) begin errors++; $display("FAIL reset_l3_addr: got %h want 0", l3_addr); end
    endtask

    task automatic test_single_i();
        i_req = 1'b1; i_addr = 64'h40; l3_req_ready = 1'b1;
        tick();
        checks++; if (i_ack !== 1'b1) begin errors++; $display("FAIL single_i_ack: got %b want 1", i_ack); end
        checks++; if (l3_req_valid !== 1'b1 || l3_addr !== 64'h40 || l3_req_we !== 1'b0) begin
            errors++; $display("FAIL single_i_issue: valid=%b addr=%h we=%b want 1 40 0", l3_req_valid, l3_addr, l3_req_we); end
        i_req = 1'b0;
        tick();
        checks++; if (l3_req_valid !== 1'b0 || i_ack !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_i_wait: valid=%b ack=%b busy=%b want 0 0 1", l3_req_valid, i_ack, busy); end
        l3_req_ready = 1'b0;
        tick();
        tick();
        l3_resp_valid = 1'b1; l3_resp_data = 64'hDEADBEEF;
        tick();
        l3_resp_valid = 1'b0;
        checks++; if (i_fill_valid !== 1'b1 || cache_read_start !== 1'b1 || d_fill_valid !== 1'b0 || w_done !== 1'b0) begin
            errors++; $display("FAIL single_i_pulse: ifill=%b crs=%b dfill=%b wdone=%b want 1 1 0 0", i_fill_valid, cache_read_start, d_fill_valid, w_done); end
        checks++; if (cache_read !== 64'h40 || cache_in !== 64'hDEADBEEF || fill_data !== 64'hDEADBEEF) begin
            errors++; $display("FAIL single_i_data: tag=%h in=%h fill=%h want 40 deadbeef deadbeef", cache_read, cache_in, fill_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_i_idle: got busy=%b want 0", busy); end
        tick();
        checks++; if (i_fill_valid !== 1'b0 || cache_read_start !== 1'b0) begin
            errors++; $display("FAIL single_i_one_cycle: ifill=%b crs=%b want 0 0", i_fill_valid, cache_read_start); end
    endtask

    task automatic test_contention();
        logic [2:0]  exp_oh   [4];
        logic [63:0] exp_addr [4];
        logic [2:0]  obs;
        int n;
        exp_oh   = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_addr = '{64'h100, 64'h200, 64'h300, 64'h100};
        i_req = 1'b1; d_req = 1'b1; w_req = 1'b1;
        i_addr = 64'h100; d_addr = 64'h200; w_addr = 64'h300; w_data = 64'h55;
        l3_req_ready = 1'b1;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while ((i_ack | d_ack | w_ack) !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            checks++; if (n >= 20) begin errors++; $display("FAIL contention_wait_ack%0d: no ack within %0d cycles", t, n); end
            obs = {w_ack, d_ack, i_ack};
            checks++; if (obs !== exp_oh[t]) begin errors++; $display("FAIL contention_grant%0d: got %b want %b", t, obs, exp_oh[t]); end
            checks++; if (l3_addr !== exp_addr[t]) begin errors++; $display("FAIL contention_addr%0d: got %h want %h", t, l3_addr, exp_addr[t]); end
            tick();
            obs = {w_ack, d_ack, i_ack};
            checks++; if (obs !== 3'b000) begin errors++; $display("FAIL contention_single_ack%0d: got %b want 000", t, obs); end
            l3_resp_valid = 1'b1; l3_resp_data = 64'h1000 + 64'(t);
            tick();
            l3_resp_valid = 1'b0;
            obs = {w_done, d_fill_valid, i_fill_valid};
            checks++; if (obs !== exp_oh[t]) begin errors++; $display("FAIL contention_done%0d: got %b want %b", t, obs, exp_oh[t]); end
            if (t == 3) begin
                i_req = 1'b0; d_req = 1'b0; w_req = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_write();
        w_req = 1'b1; w_addr = 64'h80; w_data = 64'h1234; l3_req_ready = 1'b1;
        tick();
        checks++; if (w_ack !== 1'b1 || l3_req_we !== 1'b1) begin errors++; $display("FAIL write_ack_we: ack=%b we=%b want 1 1", w_ack, l3_req_we); end
        checks++; if (l3_wdata !== 64'h1234 || l3_addr !== 64'h80) begin
            errors++; $display("FAIL write_payload: wdata=%h addr=%h want 1234 80", l3_wdata, l3_addr); end
        w_req = 1'b0;
        tick();
        l3_req_ready = 1'b0;
        l3_resp_valid = 1'b1; l3_resp_data = 64'hAAAA;
        tick();
        l3_resp_valid = 1'b0;
        checks++; if (w_done !== 1'b1 || cache_read_start !== 1'b0 || i_fill_valid !== 1'b0 || d_fill_valid !== 1'b0) begin
            errors++; $display("FAIL write_done: wdone=%b crs=%b ifill=%b dfill=%b want 1 0 0 0", w_done, cache_read_start, i_fill_valid, d_fill_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        d_req = 1'b1; d_addr = 64'h2000; l3_req_ready = 1'b0;
        tick();
        checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL bp_ack: got %b want 1", d_ack); end
        d_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (l3_req_valid !== 1'b1 || l3_addr !== 64'h2000 || d_fill_valid !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b addr=%h dfill=%b want 1 2000 0", i, l3_req_valid, l3_addr, d_fill_valid); end
            l3_resp_valid = (i == 1);
            l3_resp_data  = 64'hBAD;
            tick();
        end
        l3_resp_valid = 1'b0;
        checks++; if (l3_req_valid !== 1'b1 || d_fill_valid !== 1'b0) begin
            errors++; $display("FAIL bp_stray_resp: valid=%b dfill=%b want 1 0", l3_req_valid, d_fill_valid); end
        l3_req_ready = 1'b1;
        tick();
        l3_req_ready = 1'b0;
        checks++; if (l3_req_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL bp_accept: valid=%b busy=%b want 0 1", l3_req_valid, busy); end
        l3_resp_valid = 1'b1; l3_resp_data = 64'h77;
        tick();
        l3_resp_valid = 1'b0;
        checks++; if (d_fill_valid !== 1'b1 || fill_data !== 64'h77 || cache_read !== 64'h2000) begin
            errors++; $display("FAIL bp_fill: dfill=%b data=%h tag=%h want 1 77 2000", d_fill_valid, fill_data, cache_read); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        logic [8:0] flags;
        d_req = 1'b1; d_addr = 64'h1000; l3_req_ready = 1'b1;
        tick();
        d_req = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmw_in_wait: busy=%b want 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        flags = {i_ack, d_ack, w_ack, l3_req_valid, l3_req_we, i_fill_valid, d_fill_valid, w_done, cache_read_start};
        checks++; if (busy !== 1'b0 || flags !== 9'b0) begin
            errors++; $display("FAIL rmw_outputs: busy=%b flags=%b want 0 000000000", busy, flags); end
        checks++; if (l3_addr !== 64'h0 || fill_data !== 64'h0 || cache_read !== 64'h0) begin
            errors++; $display("FAIL rmw_payload: addr=%h fill=%h tag=%h want 0 0 0", l3_addr, fill_data, cache_read); end
        l3_resp_valid = 1'b1; l3_resp_data = 64'h99;
        tick();
        l3_resp_valid = 1'b0;
        checks++; if (d_fill_valid !== 1'b0 || cache_read_start !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmw_late_resp: dfill=%b crs=%b busy=%b want 0 0 0", d_fill_valid, cache_read_start, busy); end
        i_req = 1'b1; d_req = 1'b1; i_addr = 64'h500; d_addr = 64'h600;
        tick();
        checks++; if (i_ack !== 1'b1 || d_ack !== 1'b0) begin
            errors++; $display("FAIL rmw_rr_ptr: iack=%b dack=%b want 1 0", i_ack, d_ack); end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        l3_resp_valid = 1'b1;
        tick();
        l3_resp_valid = 1'b0;
        tick();
    endtask

`ifdef L2_ARB_TIMEOUT_EN
    task automatic test_timeout();
        d_req = 1'b1; d_addr = 64'h3000; l3_req_ready = 1'b1;
        tick();
        d_req = 1'b0;
        tick();
        l3_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (busy !== 1'b1 || timeout_err !== 1'b0 || d_fill_valid !== 1'b0) begin
                errors++; $display("FAIL tmo_waiting%0d: busy=%b err=%b dfill=%b want 1 0 0", i, busy, timeout_err, d_fill_valid); end
            tick();
        end
        checks++; if (timeout_err !== 1'b1 || d_fill_valid !== 1'b1 || fill_data !== 64'h0) begin
            errors++; $display("FAIL tmo_fire: err=%b dfill=%b data=%h want 1 1 0", timeout_err, d_fill_valid, fill_data); end
        checks++; if (cache_read_start !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL tmo_no_fill: crs=%b busy=%b want 0 0", cache_read_start, busy); end
        tick();
        checks++; if (timeout_err !== 1'b1 || d_fill_valid !== 1'b0) begin
            errors++; $display("FAIL tmo_sticky: err=%b dfill=%b want 1 0", timeout_err, d_fill_valid); end
    endtask
`else
    task automatic test_no_timeout();
        d_req = 1'b1; d_addr = 64'h3000; l3_req_ready = 1'b1;
        tick();
        d_req = 1'b0;
        tick();
        l3_req_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        checks++; if (busy !== 1'b1 || timeout_err !== 1'b0 || d_fill_valid !== 1'b0) begin
            errors++; $display("FAIL no_tmo_wait: busy=%b err=%b dfill=%b want 1 0 0", busy, timeout_err, d_fill_valid); end
        l3_resp_valid = 1'b1; l3_resp_data = 64'h42;
        tick();
        l3_resp_valid = 1'b0;
        checks++; if (d_fill_valid !== 1'b1 || fill_data !== 64'h42) begin
            errors++; $display("FAIL no_tmo_resp: dfill=%b data=%h want 1 42", d_fill_valid, fill_data); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_i();
        test_contention();
        test_write();
        test_backpressure();
        test_reset_mid_wait();
`ifdef L2_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
